// File: rtl/ctrl_fsm.sv
// Multi-cycle control state machine for the 4-bit-opcode CPU.
// Sequences every instruction through FETCH, DECODE, EXEC, MEM and WB,
// steering the PC, IR, register file, ALU operand mux, call stack and the
// memory request handshake. A memory access that stays not-ready for too
// long parks the core in HALT with a sticky error flag until reset.
module ctrl_fsm #(
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] opcode,
   input  logic       zero_flag,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       mem_sel,
   output logic       ir_load,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       reg_write,
   output logic [1:0] wb_src,
   output logic       alu_src_imm,
   output logic       sp_push,
   output logic       sp_pop,
   output logic       instr_done,
   output logic       halted,
   output logic       mem_err,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd7
   } stateT;

   localparam bit         timeoutOn = (TIMEOUT != 0);
   localparam logic [7:0] lastWait  = timeoutOn ? 8'(TIMEOUT - 1) : 8'd0;

   stateT      stateReg;
   stateT      stateNext;
   logic [7:0] waitCount;
   logic       memErr;
   logic       waitExpired;

   logic isR, isI, isLd, isSt, isJ, isCall, isRet, isBr;

   // Opcode class decode. Anything not matched here (0000, 1100-1111)
   // falls through to the NOP handling in EXEC.
   always_comb begin
      isR    = (opcode == 4'b0001) || (opcode == 4'b1001) ||
               (opcode == 4'b1010) || (opcode == 4'b1011);
      isI    = (opcode == 4'b0010);
      isLd   = (opcode == 4'b0101);
      isSt   = (opcode == 4'b0110);
      isJ    = (opcode == 4'b0011);
      isCall = (opcode == 4'b0111);
      isRet  = (opcode == 4'b1000);
      isBr   = (opcode == 4'b0100);
   end

   // A wait cycle is the last one allowed when the counter has already
   // reached TIMEOUT-1 and memory is still not ready in this cycle.
   assign waitExpired = timeoutOn && !mem_ready && (waitCount == lastWait);

   // Next-state and output decode from the registered state. Every output
   // starts at 0 and is raised only where the state calls for it; reset
   // forces the whole output set (including the debug state) back to 0 so
   // nothing is written or requested in the reset cycle.
   always_comb begin
      stateNext   = stateReg;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_sel     = 1'b0;
      ir_load     = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 2'b00;
      reg_write   = 1'b0;
      wb_src      = 2'b00;
      alu_src_imm = 1'b0;
      sp_push     = 1'b0;
      sp_pop      = 1'b0;
      instr_done  = 1'b0;
      halted      = 1'b0;
      mem_err     = memErr;
      state       = stateReg;

      case (stateReg)
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_load   = 1'b1;
               pc_write  = 1'b1;
               stateNext = DECODE;
            end else if (waitExpired) begin
               stateNext = HALT;
            end
         end
         DECODE: begin
            stateNext = EXEC;
         end
         EXEC: begin
            if (isR) begin
               stateNext = WB;
            end else if (isI) begin
               alu_src_imm = 1'b1;
               stateNext   = WB;
            end else if (isLd || isSt) begin
               alu_src_imm = 1'b1;
               stateNext   = MEM;
            end else if (isJ) begin
               pc_write   = 1'b1;
               pc_src     = 2'b01;
               instr_done = 1'b1;
               stateNext  = FETCH;
            end else if (isCall) begin
               sp_push    = 1'b1;
               pc_write   = 1'b1;
               pc_src     = 2'b01;
               instr_done = 1'b1;
               stateNext  = FETCH;
            end else if (isRet) begin
               sp_pop     = 1'b1;
               pc_write   = 1'b1;
               pc_src     = 2'b11;
               instr_done = 1'b1;
               stateNext  = FETCH;
            end else if (isBr) begin
               pc_src     = 2'b10;
               pc_write   = zero_flag;
               instr_done = 1'b1;
               stateNext  = FETCH;
            end else begin
               instr_done = 1'b1;
               stateNext  = FETCH;
            end
         end
         MEM: begin
            mem_req = 1'b1;
            mem_sel = 1'b1;
            mem_we  = isSt;
            if (mem_ready) begin
               if (isLd) begin
                  stateNext = WB;
               end else begin
                  instr_done = 1'b1;
                  stateNext  = FETCH;
               end
            end else if (waitExpired) begin
               stateNext = HALT;
            end
         end
         WB: begin
            reg_write  = 1'b1;
            wb_src     = isLd ? 2'b01 : 2'b00;
            instr_done = 1'b1;
            stateNext  = FETCH;
         end
         HALT: begin
            halted    = 1'b1;
            stateNext = HALT;
         end
         default: begin
            stateNext = FETCH;
         end
      endcase

      if (rst) begin
         mem_req     = 1'b0;
         mem_we      = 1'b0;
         mem_sel     = 1'b0;
         ir_load     = 1'b0;
         pc_write    = 1'b0;
         pc_src      = 2'b00;
         reg_write   = 1'b0;
         wb_src      = 2'b00;
         alu_src_imm = 1'b0;
         sp_push     = 1'b0;
         sp_pop      = 1'b0;
         instr_done  = 1'b0;
         halted      = 1'b0;
         mem_err     = 1'b0;
         state       = 3'd0;
      end
   end

   // State register, wait counter and sticky error flag. The counter
   // restarts on every state change so each memory access gets its own
   // budget; the error flag is set only on the way into HALT, which is
   // reachable solely through a timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         stateReg  <= FETCH;
         waitCount <= 8'd0;
         memErr    <= 1'b0;
      end else begin
         stateReg <= stateNext;
         if (stateNext != stateReg) begin
            waitCount <= 8'd0;
         end else if (((stateReg == FETCH) || (stateReg == MEM)) && !mem_ready) begin
            waitCount <= waitCount + 8'd1;
         end
         if ((stateNext == HALT) && (stateReg != HALT)) begin
            memErr <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm: a table of directed cycle vectors for
// the multi-cycle corner cases, followed by a long randomized run checked
// against a per-instruction phase-plan model.
module tb_ctrl_fsm;

   localparam int TIMEOUT = 4;

   logic       clk;
   logic       rst;
   logic [3:0] opcode;
   logic       zero_flag;
   logic       mem_ready;
   logic       mem_req, mem_we, mem_sel, ir_load, pc_write, reg_write;
   logic [1:0] pc_src, wb_src;
   logic       alu_src_imm, sp_push, sp_pop, instr_done, halted, mem_err;
   logic [2:0] state;

   ctrl_fsm #(.TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .opcode      (opcode),
      .zero_flag   (zero_flag),
      .mem_ready   (mem_ready),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_sel     (mem_sel),
      .ir_load     (ir_load),
      .pc_write    (pc_write),
      .pc_src      (pc_src),
      .reg_write   (reg_write),
      .wb_src      (wb_src),
      .alu_src_imm (alu_src_imm),
      .sp_push     (sp_push),
      .sp_pop      (sp_pop),
      .instr_done  (instr_done),
      .halted      (halted),
      .mem_err     (mem_err),
      .state       (state)
   );

   // Free-running 10-time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One bit per single-bit output, in the order they are packed below.
   localparam logic [11:0] MREQ = 12'h800;
   localparam logic [11:0] MWE  = 12'h400;
   localparam logic [11:0] MSEL = 12'h200;
   localparam logic [11:0] IRL  = 12'h100;
   localparam logic [11:0] PCW  = 12'h080;
   localparam logic [11:0] RW   = 12'h040;
   localparam logic [11:0] IMM  = 12'h020;
   localparam logic [11:0] PUSH = 12'h010;
   localparam logic [11:0] POP  = 12'h008;
   localparam logic [11:0] DONE = 12'h004;
   localparam logic [11:0] HLT  = 12'h002;
   localparam logic [11:0] MERR = 12'h001;
   localparam logic [11:0] NONE = 12'h000;
   localparam logic [11:0] FRDY = MREQ | IRL | PCW;

   localparam int C_NOP = 0, C_R = 1, C_I = 2, C_LD = 3, C_ST = 4;
   localparam int C_J = 5, C_CALL = 6, C_RET = 7, C_BR = 8;

   typedef struct {
      logic        rstV;
      logic [3:0]  op;
      logic        zf;
      logic        rdy;
      logic [11:0] mask;
      logic [1:0]  pcs;
      logic [1:0]  wbs;
      logic [2:0]  st;
      string       name;
   } vecT;

   vecT vecs[$];
   int  errors = 0;
   int  checks = 0;

   // Reference model state: position in the current instruction's phase
   // plan, consecutive wait cycles, and halt/error flags.
   int         mIdx;
   int         mWaits;
   bit         mHalt;
   bit         mErr;
   logic [3:0] mOp;
   logic       mZf;

   function automatic logic [18:0] dutOutputs();
      return {mem_req, mem_we, mem_sel, ir_load, pc_write, reg_write,
              alu_src_imm, sp_push, sp_pop, instr_done, halted, mem_err,
              pc_src, wb_src, state};
   endfunction

   function automatic int opClass(input logic [3:0] op);
      case (op)
         4'b0001, 4'b1001, 4'b1010, 4'b1011: return C_R;
         4'b0010: return C_I;
         4'b0101: return C_LD;
         4'b0110: return C_ST;
         4'b0011: return C_J;
         4'b0111: return C_CALL;
         4'b1000: return C_RET;
         4'b0100: return C_BR;
         default: return C_NOP;
      endcase
   endfunction

   // Number of cycles an instruction occupies with zero-wait memory.
   function automatic int planLen(input logic [3:0] op);
      case (opClass(op))
         C_R, C_I, C_ST: return 4;
         C_LD:           return 5;
         default:        return 3;
      endcase
   endfunction

   // Which phase (visible as the debug state) step idx of the plan is.
   function automatic int phaseAt(input logic [3:0] op, input int idx);
      int c;
      c = opClass(op);
      if (idx < 3) return idx;
      if (idx == 3) return ((c == C_LD) || (c == C_ST)) ? 3 : 4;
      return 4;
   endfunction

   function automatic logic [18:0] expOut(input logic r, input bit h, input bit e,
                                          input int ph, input logic [3:0] op,
                                          input logic zf, input logic rdy);
      logic [11:0] m;
      logic [1:0]  p;
      logic [1:0]  w;
      int          c;
      m = NONE;
      p = 2'b00;
      w = 2'b00;
      c = opClass(op);
      if (r) return 19'd0;
      if (h) return {HLT | (e ? MERR : NONE), 2'b00, 2'b00, 3'd7};
      case (ph)
         0: m = rdy ? FRDY : MREQ;
         2: begin
            case (c)
               C_I, C_LD, C_ST: m = IMM;
               C_J:    begin m = PCW | DONE;        p = 2'b01; end
               C_CALL: begin m = PUSH | PCW | DONE; p = 2'b01; end
               C_RET:  begin m = POP | PCW | DONE;  p = 2'b11; end
               C_BR:   begin m = DONE | (zf ? PCW : NONE); p = 2'b10; end
               C_NOP:  m = DONE;
               default: m = NONE;
            endcase
         end
         3: begin
            m = MREQ | MSEL;
            if (c == C_ST) m = m | MWE | (rdy ? DONE : NONE);
         end
         4: begin
            m = RW | DONE;
            w = (c == C_LD) ? 2'b01 : 2'b00;
         end
         default: m = NONE;
      endcase
      return {m, p, w, 3'(ph)};
   endfunction

   // Advance the model across one rising edge.
   task automatic modelStep(input logic r, input logic rdy);
      int ph;
      if (r) begin
         mIdx = 0; mWaits = 0; mHalt = 0; mErr = 0;
      end else if (!mHalt) begin
         ph = phaseAt(mOp, mIdx);
         if (((ph == 0) || (ph == 3)) && !rdy) begin
            mWaits++;
            if ((TIMEOUT != 0) && (mWaits == TIMEOUT)) begin
               mHalt = 1; mErr = 1;
            end
         end else begin
            mWaits = 0;
            mIdx++;
            if (mIdx >= planLen(mOp)) mIdx = 0;
         end
      end
   endtask

   task automatic addVec(input logic r, input logic [3:0] op, input logic zf,
                         input logic rdy, input logic [11:0] mask,
                         input logic [1:0] pcs, input logic [1:0] wbs,
                         input logic [2:0] st, input string name);
      vecT v;
      v.rstV = r; v.op = op; v.zf = zf; v.rdy = rdy; v.mask = mask;
      v.pcs = pcs; v.wbs = wbs; v.st = st; v.name = name;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input logic r, input logic [3:0] op,
                                input logic zf, input logic rdy);
      rst       = r;
      opcode    = op;
      zero_flag = zf;
      mem_ready = rdy;
   endtask

   task automatic checkOutput(input string name, input logic [18:0] exp);
      logic [18:0] act;
      act = dutOutputs();
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %05h expected %05h", name, act, exp);
      end
   endtask

   initial begin
      logic r;
      logic rdy;

      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);

      // Reset, then R-type with zero-wait memory.
      addVec(1, 4'b0001, 0, 1, NONE, 2'b00, 2'b00, 3'd0, "reset");
      addVec(0, 4'b0001, 0, 1, FRDY, 2'b00, 2'b00, 3'd0, "r_fetch");
      addVec(0, 4'b0001, 0, 1, NONE, 2'b00, 2'b00, 3'd1, "r_decode");
      addVec(0, 4'b0001, 0, 1, NONE, 2'b00, 2'b00, 3'd2, "r_exec");
      addVec(0, 4'b0001, 0, 1, RW | DONE, 2'b00, 2'b00, 3'd4, "r_wb");
      // LD with two MEM wait cycles.
      addVec(0, 4'b0101, 0, 1, FRDY, 2'b00, 2'b00, 3'd0, "ld_fetch");
      addVec(0, 4'b0101, 0, 1, NONE, 2'b00, 2'b00, 3'd1, "ld_decode");
      addVec(0, 4'b0101, 0, 1, IMM, 2'b00, 2'b00, 3'd2, "ld_exec");
      addVec(0, 4'b0101, 0, 0, MREQ | MSEL, 2'b00, 2'b00, 3'd3, "ld_mem_wait1");
      addVec(0, 4'b0101, 0, 0, MREQ | MSEL, 2'b00, 2'b00, 3'd3, "ld_mem_wait2");
      addVec(0, 4'b0101, 0, 1, MREQ | MSEL, 2'b00, 2'b00, 3'd3, "ld_mem_done");
      addVec(0, 4'b0101, 0, 1, RW | DONE, 2'b00, 2'b01, 3'd4, "ld_wb");
      // Branch taken, then not taken.
      addVec(0, 4'b0100, 1, 1, FRDY, 2'b00, 2'b00, 3'd0, "br1_fetch");
      addVec(0, 4'b0100, 1, 1, NONE, 2'b00, 2'b00, 3'd1, "br1_decode");
      addVec(0, 4'b0100, 1, 1, PCW | DONE, 2'b10, 2'b00, 3'd2, "br_taken");
      addVec(0, 4'b0100, 0, 1, FRDY, 2'b00, 2'b00, 3'd0, "br2_fetch");
      addVec(0, 4'b0100, 0, 1, NONE, 2'b00, 2'b00, 3'd1, "br2_decode");
      addVec(0, 4'b0100, 0, 1, DONE, 2'b10, 2'b00, 3'd2, "br_not_taken");
      // CALL then RET, then J and I.
      addVec(0, 4'b0111, 0, 1, FRDY, 2'b00, 2'b00, 3'd0, "call_fetch");
      addVec(0, 4'b0111, 0, 1, NONE, 2'b00, 2'b00, 3'd1, "call_decode");
      addVec(0, 4'b0111, 0, 1, PUSH | PCW | DONE, 2'b01, 2'b00, 3'd2, "call_exec");
      addVec(0, 4'b1000, 0, 1, FRDY, 2'b00, 2'b00, 3'd0, "ret_fetch");
      addVec(0, 4'b1000, 0, 1, NONE, 2'b00, 2'b00, 3'd1, "ret_decode");
      addVec(0, 4'b1000, 0, 1, POP | PCW | DONE, 2'b11, 2'b00, 3'd2, "ret_exec");
      addVec(0, 4'b0011, 0, 1, FRDY, 2'b00, 2'b00, 3'd0, "j_fetch");
      addVec(0, 4'b0011, 0, 1, NONE, 2'b00, 2'b00, 3'd1, "j_decode");
      addVec(0, 4'b0011, 0, 1, PCW | DONE, 2'b01, 2'b00, 3'd2, "j_exec");
      addVec(0, 4'b0010, 0, 1, FRDY, 2'b00, 2'b00, 3'd0, "i_fetch");
      addVec(0, 4'b0010, 0, 1, NONE, 2'b00, 2'b00, 3'd1, "i_decode");
      addVec(0, 4'b0010, 0, 1, IMM, 2'b00, 2'b00, 3'd2, "i_exec");
      addVec(0, 4'b0010, 0, 1, RW | DONE, 2'b00, 2'b00, 3'd4, "i_wb");
      // Fetch timeout: four not-ready cycles, then HALT until reset.
      addVec(0, 4'b0000, 0, 0, MREQ, 2'b00, 2'b00, 3'd0, "to_wait1");
      addVec(0, 4'b0000, 0, 0, MREQ, 2'b00, 2'b00, 3'd0, "to_wait2");
      addVec(0, 4'b0000, 0, 0, MREQ, 2'b00, 2'b00, 3'd0, "to_wait3");
      addVec(0, 4'b0000, 0, 0, MREQ, 2'b00, 2'b00, 3'd0, "to_wait4");
      addVec(0, 4'b0000, 0, 0, HLT | MERR, 2'b00, 2'b00, 3'd7, "to_halt");
      addVec(0, 4'b0000, 0, 1, HLT | MERR, 2'b00, 2'b00, 3'd7, "halt_sticky");
      addVec(1, 4'b0000, 0, 1, NONE, 2'b00, 2'b00, 3'd0, "halt_reset");
      // Same again, but ready arrives on the fourth cycle.
      addVec(0, 4'b1111, 0, 0, MREQ, 2'b00, 2'b00, 3'd0, "edge_wait1");
      addVec(0, 4'b1111, 0, 0, MREQ, 2'b00, 2'b00, 3'd0, "edge_wait2");
      addVec(0, 4'b1111, 0, 0, MREQ, 2'b00, 2'b00, 3'd0, "edge_wait3");
      addVec(0, 4'b1111, 0, 1, FRDY, 2'b00, 2'b00, 3'd0, "edge_ready4");
      addVec(0, 4'b1111, 0, 1, NONE, 2'b00, 2'b00, 3'd1, "edge_decode");
      addVec(0, 4'b1111, 0, 1, DONE, 2'b00, 2'b00, 3'd2, "nop_exec");
      // Store interrupted by reset in MEM, then a full store and a NOP.
      addVec(0, 4'b0110, 0, 1, FRDY, 2'b00, 2'b00, 3'd0, "st_fetch");
      addVec(0, 4'b0110, 0, 1, NONE, 2'b00, 2'b00, 3'd1, "st_decode");
      addVec(0, 4'b0110, 0, 1, IMM, 2'b00, 2'b00, 3'd2, "st_exec");
      addVec(0, 4'b0110, 0, 0, MREQ | MSEL | MWE, 2'b00, 2'b00, 3'd3, "st_mem_wait");
      addVec(1, 4'b0110, 0, 1, NONE, 2'b00, 2'b00, 3'd0, "st_mem_reset");
      addVec(0, 4'b0110, 0, 1, FRDY, 2'b00, 2'b00, 3'd0, "st2_fetch");
      addVec(0, 4'b0110, 0, 1, NONE, 2'b00, 2'b00, 3'd1, "st2_decode");
      addVec(0, 4'b0110, 0, 1, IMM, 2'b00, 2'b00, 3'd2, "st2_exec");
      addVec(0, 4'b0110, 0, 1, MREQ | MSEL | MWE | DONE, 2'b00, 2'b00, 3'd3, "st2_mem");
      addVec(0, 4'b1100, 0, 1, FRDY, 2'b00, 2'b00, 3'd0, "nop_fetch");
      addVec(0, 4'b1100, 0, 1, NONE, 2'b00, 2'b00, 3'd1, "nop_decode");
      addVec(0, 4'b1100, 0, 1, DONE, 2'b00, 2'b00, 3'd2, "nop2_exec");
      addVec(0, 4'b1100, 0, 1, FRDY, 2'b00, 2'b00, 3'd0, "after_nop_fetch");

      $display("[TB] directed vectors: %0d", vecs.size());
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rstV, vecs[i].op, vecs[i].zf, vecs[i].rdy);
         @(negedge clk);
         checkOutput(vecs[i].name, {vecs[i].mask, vecs[i].pcs, vecs[i].wbs, vecs[i].st});
         @(posedge clk);
         #1;
      end

      // Randomized run against the phase-plan model, starting from reset.
      mOp = 4'b0000;
      mZf = 1'b0;
      applyStimulus(1'b1, mOp, mZf, 1'b1);
      @(negedge clk);
      checkOutput("rand_reset", 19'd0);
      @(posedge clk);
      #1;
      modelStep(1'b1, 1'b1);

      for (int n = 0; n < 3000; n++) begin
         r   = ($urandom_range(0, 99) == 0) || (mHalt && ($urandom_range(0, 3) == 0));
         rdy = ($urandom_range(0, 9) < 7);
         if ((mIdx == 0) && !mHalt) begin
            mOp = 4'($urandom_range(0, 15));
            mZf = 1'($urandom_range(0, 1));
         end
         applyStimulus(r, mOp, mZf, rdy);
         @(negedge clk);
         checkOutput("random", expOut(r, mHalt, mErr, phaseAt(mOp, mIdx), mOp, mZf, rdy));
         @(posedge clk);
         #1;
         modelStep(r, rdy);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ctrl_fsm.md
# ctrl_fsm

Multi-cycle control state machine for the 4-bit-opcode CPU. It sequences each instruction through fetch, decode, execute, memory and write-back, and drives the PC, instruction register, register file, ALU operand mux, call/return stack and memory request handshake. It sits between the instruction register / opcode type decode and the datapath. It also halts the core on a memory handshake timeout.

## Interface
- TIMEOUT, 15: consecutive not-ready cycles of one memory access before halting; range 0..255; 0 disables the timeout.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  4  instruction opcode from the IR; valid from DECODE onward
- zero_flag  in  1  ALU zero result, sampled in EXEC for branches
- mem_ready  in  1  memory completes the current request in this cycle
- mem_req  out  1  memory request active
- mem_we  out  1  write request (store only)
- mem_sel  out  1  address source: 0 = PC (fetch), 1 = ALU result (data)
- ir_load  out  1  load IR from memory read data
- pc_write  out  1  update PC this cycle
- pc_src  out  2  00 = PC+1, 01 = jump target, 10 = branch target, 11 = stack top
- reg_write  out  1  register file write enable
- wb_src  out  2  00 = ALU, 01 = memory data, 10/11 unused (driven 00)
- alu_src_imm  out  1  ALU B operand: 0 = register, 1 = immediate
- sp_push  out  1  push current PC (already incremented) onto the call stack
- sp_pop  out  1  pop the call stack
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- halted  out  1  core is in HALT
- mem_err  out  1  sticky timeout flag
- state  out  3  current state, for debug

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7. Codes 5 and 6 go to FETCH.
- Opcode classes:
  - R = 0001, 1001, 1010, 1011
  - I = 0010
  - LD = 0101
  - ST = 0110
  - J = 0011
  - CALL = 0111
  - RET = 1000
  - BR = 0100
  - NOP = 0000 and 1100–1111
- All outputs not listed for a state are 0. Outputs are decoded combinationally from the registered state, opcode, zero_flag and mem_ready.
- FETCH:
  - Drive mem_req=1, mem_sel=0.
  - When mem_ready=1: ir_load=1, pc_write=1, pc_src=00; next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: register read cycle, no outputs asserted; always go to EXEC.
- EXEC:
  - R: alu_src_imm=0; next state WB.
  - I: alu_src_imm=1; next state WB.
  - LD/ST: alu_src_imm=1 (address calculation); next state MEM.
  - J: pc_write=1, pc_src=01, instr_done=1; next state FETCH.
  - CALL: sp_push=1, pc_write=1, pc_src=01, instr_done=1; next state FETCH.
  - RET: sp_pop=1, pc_write=1, pc_src=11, instr_done=1; next state FETCH.
  - BR: pc_src=10, pc_write=zero_flag, instr_done=1; next state FETCH.
  - NOP: instr_done=1; next state FETCH.
- MEM:
  - Drive mem_req=1, mem_sel=1, mem_we=1 for ST only.
  - Hold until mem_ready=1. Then LD goes to WB; ST asserts instr_done and goes to FETCH.
- WB: reg_write=1, wb_src=01 for LD and 00 otherwise, instr_done=1; next state FETCH.
- Wait counter (8 bit):
  - Clears on every state transition.
  - Increments each cycle spent in FETCH or MEM with mem_ready=0.
  - If TIMEOUT≠0, mem_ready=0 and the counter equals TIMEOUT-1, the next state is HALT and mem_err is set.
  - mem_ready=1 in any cycle completes the access, including the TIMEOUT-th cycle.
- HALT: all outputs 0 except halted=1, state=7 and mem_err. Only rst exits HALT.

## Timing
- Reset:
  - On a rising edge with rst=1: state←FETCH, counter←0, mem_err←0.
  - While rst=1, all outputs are forced to 0, including state.
  - In the first cycle after rst falls: state=0, mem_req=1.
- Reset mid-operation (any state, including HALT, MEM with write pending) returns to FETCH on the next edge; no write-back or PC update occurs in the reset cycle.
- Latency with zero-wait memory (mem_ready=1 on first request cycle):
  - R, I, ST: 4 cycles.
  - LD: 5 cycles.
  - J, CALL, RET, BR, NOP: 3 cycles.
  - Each wait cycle adds 1.
- mem_req stays high, and mem_sel / mem_we stay stable, until the cycle mem_ready=1. Asserting mem_ready while mem_req=0 is ignored.
- instr_done is high for exactly one cycle per instruction: the cycle before returning to FETCH.
- opcode and zero_flag must be stable from DECODE through the end of the instruction. The IR only loads in FETCH.

## Test plan
- Reset, then R opcode 0001 with mem_ready tied 1 -> states 0,1,2,4,0. ir_load in cycle 1, reg_write=1/wb_src=00 in cycle 4, instr_done only in cycle 4.
- LD 0101 with mem_ready low for 2 MEM cycles -> MEM lasts 3 cycles with mem_sel=1, mem_we=0. WB asserts wb_src=01. Total 7 cycles.
- BR 0100 twice: zero_flag=1 then 0 -> pc_write=1/pc_src=10 in the first EXEC, pc_write=0 in the second. Both take 3 cycles.
- CALL 0111 then RET 1000 -> sp_push with pc_src=01, then sp_pop with pc_src=11. No reg_write in either.
- TIMEOUT=4, mem_ready held 0 in FETCH -> 4 FETCH cycles, then HALT with halted=1 and mem_err=1. Pulse rst -> state 0, mem_err=0. Repeat with mem_ready=1 in the 4th cycle -> DECODE, no halt.
- rst asserted during MEM of ST 0110 -> all outputs 0 that cycle, FETCH next. Opcode 1111 -> 3-cycle NOP with no writes.
